// File: rtl/multi_channel_clip_pkg.sv
// ============================================================================
// multi_channel_clip_pkg : shared FSM states, mode codes and arithmetic constants
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package multi_channel_clip_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_PROC    = 3'd2,
    S_OUTPUT  = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_HARD   = 2'b01;
  localparam logic [1:0] MODE_SOFT   = 2'b10;

  localparam int GAIN_FRAC_BITS = 4;
  localparam int SOFT_SHIFT     = 2;

endpackage

`default_nettype wire

// File: rtl/multi_channel_clip_if.sv
// ============================================================================
// multi_channel_clip_if : source/sink handshake and per-frame config bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface multi_channel_clip_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int GAIN_WIDTH = 8
) ();

  logic [CHANNELS*DATA_WIDTH-1:0] i_data;
  logic                           i_data_ready;
  logic                           o_read_enable;
  logic [DATA_WIDTH-1:0]          i_treshhold;
  logic [GAIN_WIDTH-1:0]          i_gain;
  logic [1:0]                     i_mode;
  logic [CHANNELS*DATA_WIDTH-1:0] o_data;
  logic                           o_data_valid;
  logic                           i_read_done;

  modport slave (
    input  i_data, i_data_ready, i_treshhold, i_gain, i_mode, i_read_done,
    output o_read_enable, o_data, o_data_valid
  );

  modport master (
    output i_data, i_data_ready, i_treshhold, i_gain, i_mode, i_read_done,
    input  o_read_enable, o_data, o_data_valid
  );

endinterface

`default_nettype wire

// File: rtl/multi_channel_clip_core.sv
// ============================================================================
// multi_channel_clip_core (clip_core) : combinational gain, saturate and clip of one channel
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module multi_channel_clip_core
  import multi_channel_clip_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 8
) (
  input  wire logic [DATA_WIDTH-1:0] i_x,
  input  wire logic [GAIN_WIDTH-1:0] i_gain,
  input  wire logic [DATA_WIDTH-1:0] i_thresh,
  input  wire logic [1:0]            i_mode,
  output logic      [DATA_WIDTH-1:0] o_y,
  output logic                       o_clipped
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [DATA_WIDTH:0]  MAG_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};

  logic signed [PW-1:0]   w_x_ext;
  logic signed [PW-1:0]   w_g_ext;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_scaled;
  logic [DATA_WIDTH-1:0]  w_p;
  logic                   w_neg;
  logic [DATA_WIDTH:0]    w_p_ext;
  logic [DATA_WIDTH:0]    w_abs;
  logic [DATA_WIDTH:0]    w_t_ext;
  logic [DATA_WIDTH:0]    w_excess;
  logic [DATA_WIDTH:0]    w_soft_mag;
  logic [DATA_WIDTH:0]    w_lim_mag;
  logic [DATA_WIDTH:0]    w_lim_signed;
  logic                   w_over;
  logic                   w_engaged;

  assign w_x_ext  = {{(GAIN_WIDTH+1){i_x[DATA_WIDTH-1]}}, i_x};
  assign w_g_ext  = {{(DATA_WIDTH+1){1'b0}}, i_gain};
  assign w_prod   = w_x_ext * w_g_ext;
  assign w_scaled = w_prod >>> GAIN_FRAC_BITS;

  always_comb begin
    w_p = w_scaled[DATA_WIDTH-1:0];
    if (w_scaled > SAT_MAX) begin
      w_p = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_scaled < SAT_MIN) begin
      w_p = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Magnitude is one bit wider so that the most negative sample does not wrap.
  assign w_neg      = w_p[DATA_WIDTH-1];
  assign w_p_ext    = {w_p[DATA_WIDTH-1], w_p};
  assign w_abs      = w_neg ? (~w_p_ext + 1'b1) : w_p_ext;
  assign w_t_ext    = {1'b0, i_thresh};
  assign w_over     = w_abs > w_t_ext;
  assign w_excess   = w_abs - w_t_ext;
  assign w_soft_mag = w_t_ext + (w_excess >> SOFT_SHIFT);

  always_comb begin
    w_lim_mag = w_t_ext;
    if (i_mode == MODE_SOFT) begin
      w_lim_mag = (w_soft_mag > MAG_MAX) ? MAG_MAX : w_soft_mag;
    end
  end

  // Mode 2'b11 falls through to the hard limit.
  assign w_lim_signed = w_neg ? (~w_lim_mag + 1'b1) : w_lim_mag;
  assign w_engaged    = w_over && (i_mode != MODE_BYPASS);
  assign o_y          = w_engaged ? w_lim_signed[DATA_WIDTH-1:0] : w_p;
  assign o_clipped    = w_engaged;

endmodule

`default_nettype wire

// File: rtl/multi_channel_clip.sv
// ============================================================================
// multi_channel_clip : frame FSM applying per-channel gain and bypass/hard/soft clip
// Optional feature macro CLIP_COUNT_EN adds the o_clip_count port.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module multi_channel_clip
  import multi_channel_clip_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int GAIN_WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  multi_channel_clip_if.slave bus
`ifdef CLIP_COUNT_EN
  ,
  output logic [15:0]       o_clip_count
`endif
);

  localparam int             CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0]  LAST_CH = CW'(CHANNELS - 1);

  state_t                              r_state;
  state_t                              w_next_state;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] r_frame;
  logic [DATA_WIDTH-1:0]               r_thresh;
  logic [GAIN_WIDTH-1:0]               r_gain;
  logic [1:0]                          r_mode;
  logic [CW-1:0]                       r_ch;
  logic                                r_read_enable;
  logic                                r_data_valid;
  logic [DATA_WIDTH-1:0]               w_y;
  logic                                w_clipped;
  logic                                w_accept;

  assign w_accept = (r_state == S_IDLE) && r_read_enable && bus.i_data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_PROC;
      S_PROC:    if (r_ch == LAST_CH) w_next_state = S_OUTPUT;
      S_OUTPUT:  if (bus.i_read_done) w_next_state = S_CLEAR;
      S_CLEAR:   w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  multi_channel_clip_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .GAIN_WIDTH (GAIN_WIDTH)
  ) u_clip_core (
    .i_x       (r_frame[r_ch]),
    .i_gain    (r_gain),
    .i_thresh  (r_thresh),
    .i_mode    (r_mode),
    .o_y       (w_y),
    .o_clipped (w_clipped)
  );

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame       <= '0;
      r_thresh      <= '0;
      r_gain        <= '0;
      r_mode        <= MODE_BYPASS;
      r_ch          <= '0;
      r_read_enable <= 1'b0;
      r_data_valid  <= 1'b0;
    end else begin
      r_read_enable <= (w_next_state == S_IDLE) || (w_next_state == S_CLEAR);
      r_data_valid  <= (w_next_state == S_OUTPUT);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_frame  <= bus.i_data;
            r_thresh <= bus.i_treshhold;
            r_gain   <= bus.i_gain;
            r_mode   <= bus.i_mode;
          end
        end
        S_CAPTURE: begin
          r_ch <= '0;
          if (r_thresh[DATA_WIDTH-1]) begin
            r_thresh <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
          end
        end
        S_PROC: begin
          r_frame[r_ch] <= w_y;
          r_ch          <= r_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data        = r_frame;
  assign bus.o_data_valid  = r_data_valid;
  assign bus.o_read_enable = r_read_enable;

`ifdef CLIP_COUNT_EN
  logic [15:0] r_clip_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clip_count <= '0;
    end else if ((r_state == S_PROC) && w_clipped && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign o_clip_count = r_clip_count;
`endif

endmodule

`default_nettype wire
